// File: rtl/gd_iteration_ctrl.sv
// gd_iteration_ctrl
//   Sequencer for one batch-gradient-descent run of linear regression.
//   Owns the theta register, registers the residual vector between the
//   X*theta - Y and X^T-multiply datapaths, registers the gradient and applies
//   theta <- sat16(theta - (gradient >>> alpha_shift)) for num_iters iterations.
//
//   Optional feature macro: GD_EARLY_STOP_EN
//     defined   : in BWD, if every |gradient[k]| <= GRAD_TOL the run stops early
//                 (no theta update, iter_count unchanged, converged <= 1).
//     undefined : comparison logic absent, converged tied to 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a run (sampled only in IDLE)
//   theta_init   initial theta, 16*n signed, element 0 in the MSBs
//   num_iters    iteration count, latched at start
//   alpha_shift  learning-rate shift, latched at start
//   xtheta_y     residual vector (32*m), combinational from theta_out
//   gradient     gradient (32*n), combinational from xtheta_y_q
//   theta_out    current theta register
//   xtheta_y_q   registered residual feeding the X^T-multiply datapath
//   iter_count   completed iterations of the current/last run
//   busy         high in every state except IDLE
//   done         one-cycle pulse in DONE
//   converged    early-stop flag, held until next start
//
// State | meaning
// IDLE  | waiting for start; results held
// FWD   | capture residual X*theta - Y
// BWD   | capture gradient (early-stop check when enabled)
// UPD   | theta update, iteration counted
// DONE  | done pulse, return to IDLE
module gd_iteration_ctrl #(
  parameter int m        = 20,
  parameter int n        = 3,
  parameter int ITER_W   = 8,
  parameter int GRAD_TOL = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16*n-1:0]     theta_init,
  input  logic [ITER_W-1:0]   num_iters,
  input  logic [4:0]          alpha_shift,
  input  logic [32*m-1:0]     xtheta_y,
  input  logic [32*n-1:0]     gradient,
  output logic [16*n-1:0]     theta_out,
  output logic [32*m-1:0]     xtheta_y_q,
  output logic [ITER_W-1:0]   iter_count,
  output logic                busy,
  output logic                done,
  output logic                converged
);

  typedef enum logic [2:0] {IDLE, FWD, BWD, UPD, DONE} state_t;

  state_t              state_q, state_d;
  logic [16*n-1:0]     theta_q;
  logic [16*n-1:0]     theta_upd;
  logic [32*n-1:0]     grad_q;
  logic [ITER_W-1:0]   iter_q;
  logic [ITER_W-1:0]   iter_next;
  logic [ITER_W-1:0]   num_iters_q;
  logic [4:0]          alpha_q;
  logic                early_stop;

  // Subtraction at 33 bits so neither operand can overflow before the clamp.
  function automatic logic [15:0] upd_elem(input logic [15:0] t,
                                           input logic [31:0] g,
                                           input logic [4:0]  sh);
    logic signed [31:0] g_sh;
    logic signed [32:0] diff;
    g_sh = $signed(g) >>> sh;
    diff = $signed({{17{t[15]}}, t}) - $signed({g_sh[31], g_sh});
    if (diff > 33'sd32767)
      return 16'h7fff;
    else if (diff < -33'sd32768)
      return 16'h8000;
    else
      return diff[15:0];
  endfunction

  always_comb begin
    theta_upd = '0;
    for (int k = 0; k < n; k++) begin
      theta_upd[16*(n-k)-1 -: 16] = upd_elem(theta_q[16*(n-k)-1 -: 16],
                                             grad_q[32*(n-k)-1 -: 32],
                                             alpha_q);
    end
  end

  assign iter_next = iter_q + ITER_W'(1);

`ifdef GD_EARLY_STOP_EN
  logic converged_q;

  // Window compare rather than abs() so -2^31 cannot wrap into range.
  always_comb begin
    early_stop = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (($signed(gradient[32*(n-k)-1 -: 32]) > GRAD_TOL) ||
          ($signed(gradient[32*(n-k)-1 -: 32]) < -GRAD_TOL))
        early_stop = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      converged_q <= 1'b0;
    else if (state_q == IDLE && start)
      converged_q <= 1'b0;
    else if (state_q == BWD && early_stop)
      converged_q <= 1'b1;
  end

  assign converged = converged_q;
`else
  assign early_stop = 1'b0;
  assign converged  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (num_iters == '0) ? DONE : FWD;
      FWD:  state_d = BWD;
      BWD:  state_d = early_stop ? DONE : UPD;
      UPD:  state_d = (iter_next == num_iters_q) ? DONE : FWD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_q     <= '0;
      xtheta_y_q  <= '0;
      grad_q      <= '0;
      iter_q      <= '0;
      num_iters_q <= '0;
      alpha_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          theta_q     <= theta_init;
          iter_q      <= '0;
          num_iters_q <= num_iters;
          alpha_q     <= alpha_shift;
        end
        FWD: xtheta_y_q <= xtheta_y;
        BWD: grad_q     <= gradient;
        UPD: begin
          theta_q <= theta_upd;
          iter_q  <= iter_next;
        end
        default: ;
      endcase
    end
  end

  assign theta_out  = theta_q;
  assign iter_count = iter_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_gd_iteration_ctrl.sv
module tb_gd_iteration_ctrl;
  localparam int M = 20;
  localparam int N = 3;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [16*N-1:0]   theta_init = '0;
  logic [IW-1:0]     num_iters = '0;
  logic [4:0]        alpha_shift = '0;
  logic [32*M-1:0]   xtheta_y;
  logic [32*N-1:0]   gradient = '0;
  logic [16*N-1:0]   theta_out;
  logic [32*M-1:0]   xtheta_y_q;
  logic [IW-1:0]     iter_count;
  logic              busy, done, converged;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string          tag;
    logic [16*N-1:0] theta;
    logic [IW-1:0]   iters;
    logic            conv;
    int              cyc;
  } exp_t;

  exp_t sb[$];

  gd_iteration_ctrl #(.m(M), .n(N), .ITER_W(IW), .GRAD_TOL(16)) dut (
    .clk(clk), .rst(rst), .start(start), .theta_init(theta_init),
    .num_iters(num_iters), .alpha_shift(alpha_shift), .xtheta_y(xtheta_y),
    .gradient(gradient), .theta_out(theta_out), .xtheta_y_q(xtheta_y_q),
    .iter_count(iter_count), .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  function automatic logic [16*N-1:0] p3(input int a, input int b, input int c);
    return {16'(a), 16'(b), 16'(c)};
  endfunction

  function automatic logic [32*N-1:0] g3(input int a, input int b, input int c);
    return {32'(a), 32'(b), 32'(c)};
  endfunction

  // Reference model of the update, written with plain integers.
  function automatic logic [16*N-1:0] model(input logic [16*N-1:0] th,
                                            input logic [32*N-1:0] gr,
                                            input int sh, input int iters);
    longint t [N];
    longint g, d;
    logic [16*N-1:0] r;
    for (int k = 0; k < N; k++) t[k] = longint'($signed(th[16*(N-k)-1 -: 16]));
    for (int i = 0; i < iters; i++)
      for (int k = 0; k < N; k++) begin
        g = longint'($signed(gr[32*(N-k)-1 -: 32]));
        d = t[k] - (g >>> sh);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        t[k] = d;
      end
    r = '0;
    for (int k = 0; k < N; k++) r[16*(N-k)-1 -: 16] = 16'(t[k]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input string tag, input logic [16*N-1:0] th,
                        input logic [IW-1:0] ni, input logic [4:0] sh,
                        input logic [32*N-1:0] gr, input logic [16*N-1:0] exp_th,
                        input logic [IW-1:0] exp_it, input logic exp_conv,
                        input int exp_cyc, input bit restart_pulse);
    int   c;
    bit   got;
    exp_t e;
    sb.push_back('{tag, exp_th, exp_it, exp_conv, exp_cyc});
    @(negedge clk);
    theta_init  = th;
    num_iters   = ni;
    alpha_shift = sh;
    gradient    = gr;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    // Post-start changes must not reach the run.
    theta_init  = ~th;
    num_iters   = 8'd3;
    alpha_shift = 5'd1;
    c   = 0;
    got = 0;
    while (!got && c < 200) begin
      @(negedge clk);
      c++;
      if (done) got = 1;
      else if (restart_pulse && c == 1) start = 1'b1;
      else if (c == 2) start = 1'b0;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, " done_seen"}, 64'(got), 64'(1));
    check({e.tag, " done_cycle"}, 64'(c), 64'(e.cyc));
    check({e.tag, " busy_at_done"}, 64'(busy), 64'(1));
    check({e.tag, " theta"}, 64'(theta_out), 64'(e.theta));
    check({e.tag, " iter_count"}, 64'(iter_count), 64'(e.iters));
    check({e.tag, " converged"}, 64'(converged), 64'(e.conv));
    @(negedge clk);
    check({e.tag, " busy_after"}, 64'(busy), 64'(0));
    check({e.tag, " done_pulse"}, 64'(done), 64'(0));
    check({e.tag, " theta_hold"}, 64'(theta_out), 64'(e.theta));
  endtask

  logic [32*M-1:0]  xt_pat;
  logic [16*N-1:0]  th_tmp;
  logic [32*N-1:0]  gr_tmp;

  initial begin
    for (int i = 0; i < M; i++) xt_pat[32*(M-i)-1 -: 32] = 32'(i * 1000 - 7000);
    xtheta_y = xt_pat;

    repeat (3) @(negedge clk);
    check("rst theta", 64'(theta_out), 64'(0));
    check("rst xq_zero", 64'(xtheta_y_q == '0), 64'(1));
    check("rst iter", 64'(iter_count), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst converged", 64'(converged), 64'(0));
    rst = 1'b0;

    do_run("zero_iter", p3(5, -6, 7), 8'd0, 5'd3, g3(64, 64, 64),
           p3(5, -6, 7), 8'd0, 1'b0, 1, 1'b0);

    do_run("single", p3(1, 2, 3), 8'd1, 5'd4, g3(64, -128, 0),
           p3(-3, 10, 3), 8'd1, 1'b0, 4, 1'b0);
    check("single xq", 64'(xtheta_y_q === xt_pat), 64'(1));

    do_run("saturate", p3(32000, -32000, 0), 8'd1, 5'd0, g3(-100000, 100000, 0),
           p3(32767, -32768, 0), 8'd1, 1'b0, 4, 1'b0);

    th_tmp = p3(100, -50, 7);
    gr_tmp = g3(32, -48, 5);
    do_run("multi", th_tmp, 8'd5, 5'd2, gr_tmp,
           model(th_tmp, gr_tmp, 2, 5), 8'd5, 1'b0, 16, 1'b1);

    do_run("neg_round", p3(0, 0, 0), 8'd1, 5'd8, g3(-300, 300, -100),
           p3(2, -1, 1), 8'd1, 1'b0, 4, 1'b0);

    // Mid-run reset in the BWD cycle of the second iteration.
    @(negedge clk);
    theta_init  = p3(111, 222, 333);
    num_iters   = 8'd5;
    alpha_shift = 5'd2;
    gradient    = g3(40, 40, 40);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst busy_before", 64'(busy), 64'(1));
    check("midrst iter_before", 64'(iter_count), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst theta", 64'(theta_out), 64'(0));
    check("midrst xq_zero", 64'(xtheta_y_q == '0), 64'(1));
    check("midrst iter", 64'(iter_count), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst converged", 64'(converged), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    do_run("post_reset", p3(1, 2, 3), 8'd1, 5'd4, g3(64, -128, 0),
           p3(-3, 10, 3), 8'd1, 1'b0, 4, 1'b0);

`ifdef GD_EARLY_STOP_EN
    do_run("early_stop", p3(1000, 1000, 1000), 8'd2, 5'd0, g3(10, -16, 3),
           p3(1000, 1000, 1000), 8'd0, 1'b1, 3, 1'b0);
`else
    do_run("no_early_stop", p3(1000, 1000, 1000), 8'd2, 5'd0, g3(10, -16, 3),
           p3(980, 1032, 994), 8'd2, 1'b0, 7, 1'b0);
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
